// File: rtl/pipe_stage_skid_pkg.sv
// Shared types and defaults for the elastic pipeline stage (package pipe_pkg).
package pipe_pkg;

    // Occupancy of the stage, decoded from the two slot valids.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;

    localparam int DEF_DATA_W  = 32;
    localparam int DEF_LANES   = 2;
    localparam int DEF_CTRL_W  = 1;
    localparam int STALL_CNT_W = 32;

    typedef logic [STALL_CNT_W-1:0] stall_cnt_t;

endpackage

// File: rtl/pipe_stage_skid_if.sv
// One valid/ready channel carrying a control bundle and LANES packed data words.
interface pipe_stage_skid_if
    import pipe_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int LANES  = DEF_LANES,
    parameter int CTRL_W = DEF_CTRL_W
);
    logic                    valid;
    logic                    ready;
    logic [CTRL_W-1:0]       ctrl;
    logic [LANES*DATA_W-1:0] data;

    modport master (output valid, output ctrl, output data, input  ready);
    modport slave  (input  valid, input  ctrl, input  data, output ready);
endinterface

// File: rtl/pipe_stage_skid_slot.sv
// One storage slot: valid + ctrl + data. Reset zeroes everything; clear only
// drops the valid bit so the data register keeps its last contents.
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int CTRL_W    = DEF_CTRL_W,
    parameter int DATA_BITS = DEF_LANES * DEF_DATA_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load_i,
    input  logic                 clear_i,
    input  logic [CTRL_W-1:0]    ctrl_i,
    input  logic [DATA_BITS-1:0] data_i,
    output logic                 valid_o,
    output logic [CTRL_W-1:0]    ctrl_o,
    output logic [DATA_BITS-1:0] data_o
);
    logic                 valid_q, valid_d;
    logic [CTRL_W-1:0]    ctrl_q,  ctrl_d;
    logic [DATA_BITS-1:0] data_q,  data_d;

    // Next-state: clear beats load so a flush drops a same-cycle accept.
    always_comb begin
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        data_d  = data_q;
        if (clear_i) begin
            valid_d = 1'b0;
        end else if (load_i) begin
            valid_d = 1'b1;
            ctrl_d  = ctrl_i;
            data_d  = data_i;
        end
    end

    // Slot register with synchronous zeroing reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign ctrl_o  = ctrl_q;
    assign data_o  = data_q;
endmodule

// File: rtl/pipe_stage_skid.sv
// Elastic pipeline stage with a 2-entry skid buffer; upstream ready is a
// register (inverse of the skid valid). Optional stall counter behind
// macro PIPE_STALL_CNT_EN.
//
//   state | meaning
//   ------+-------------------------------------------
//   EMPTY | no payload held, outputs show a bubble
//   ONE   | main slot holds the word on the outputs
//   FULL  | main and skid both held, upstream stalled
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int LANES  = DEF_LANES,
    parameter int CTRL_W = DEF_CTRL_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    pipe_stage_skid_if.slave   up,
    pipe_stage_skid_if.master  dn
`ifdef PIPE_STALL_CNT_EN
    ,
    output stall_cnt_t         stall_cnt
`endif
);
    localparam int PW = LANES * DATA_W;

    logic              main_v, skid_v;
    logic [CTRL_W-1:0] main_ctrl, skid_ctrl, main_ctrl_in;
    logic [PW-1:0]     main_data, skid_data, main_data_in;
    logic              main_load, main_clr, main_from_skid;
    logic              skid_load, skid_clr;
    logic              accept, fire;
    state_e            state;

    assign accept = up.valid & up.ready;
    assign fire   = main_v & dn.ready;

    // The slot valids are the state register; this decodes them.
    always_comb begin
        unique case ({main_v, skid_v})
            2'b10:   state = ONE;
            2'b11:   state = FULL;
            default: state = EMPTY;
        endcase
    end

    // Next-state: choose which slots load or drop for this edge.
    always_comb begin
        main_load      = 1'b0;
        main_clr       = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        skid_clr       = 1'b0;
        if (flush) begin
            main_clr = 1'b1;
            skid_clr = 1'b1;
        end else begin
            case (state)
                EMPTY: main_load = accept;
                ONE: begin
                    if (accept && fire)       main_load = 1'b1;
                    else if (accept)          skid_load = 1'b1;
                    else if (fire)            main_clr  = 1'b1;
                end
                FULL: begin
                    if (fire) begin
                        main_load      = 1'b1;
                        main_from_skid = 1'b1;
                        skid_clr       = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs: bubbles carry zero control so they never write back.
    always_comb begin
        up.ready = ~skid_v;
        dn.valid = main_v;
        dn.ctrl  = main_v ? main_ctrl : '0;
        dn.data  = main_data;
    end

    assign main_ctrl_in = main_from_skid ? skid_ctrl : up.ctrl;
    assign main_data_in = main_from_skid ? skid_data : up.data;

    pipe_slot #(.CTRL_W(CTRL_W), .DATA_BITS(PW)) u_main (
        .clk     (clk),
        .reset   (reset),
        .load_i  (main_load),
        .clear_i (main_clr),
        .ctrl_i  (main_ctrl_in),
        .data_i  (main_data_in),
        .valid_o (main_v),
        .ctrl_o  (main_ctrl),
        .data_o  (main_data)
    );

    pipe_slot #(.CTRL_W(CTRL_W), .DATA_BITS(PW)) u_skid (
        .clk     (clk),
        .reset   (reset),
        .load_i  (skid_load),
        .clear_i (skid_clr),
        .ctrl_i  (up.ctrl),
        .data_i  (up.data),
        .valid_o (skid_v),
        .ctrl_o  (skid_ctrl),
        .data_o  (skid_data)
    );

`ifdef PIPE_STALL_CNT_EN
    stall_cnt_t stall_cnt_q, stall_cnt_d;

    assign stall_cnt_d = (main_v && !dn.ready) ? stall_cnt_q + 1'b1 : stall_cnt_q;

    // Stall cycle counter; only reset clears it, it wraps naturally.
    always_ff @(posedge clk) begin
        if (reset) stall_cnt_q <= '0;
        else       stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt = stall_cnt_q;
`endif
endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid: directed table, a latency probe,
// a randomized run against a queue model, and stall-counter checks when
// PIPE_STALL_CNT_EN is defined.
module tb_pipe_stage_skid;
    import pipe_pkg::*;

    localparam int DATA_W = 32;
    localparam int LANES  = 2;
    localparam int CTRL_W = 1;
    localparam int PW     = LANES * DATA_W;

    logic clk = 1'b0;
    logic reset;
    logic flush;
    always #5 clk = ~clk;

    pipe_stage_skid_if #(.DATA_W(DATA_W), .LANES(LANES), .CTRL_W(CTRL_W)) up_if ();
    pipe_stage_skid_if #(.DATA_W(DATA_W), .LANES(LANES), .CTRL_W(CTRL_W)) dn_if ();

`ifdef PIPE_STALL_CNT_EN
    stall_cnt_t stall_cnt;
`endif

    pipe_stage_skid #(.DATA_W(DATA_W), .LANES(LANES), .CTRL_W(CTRL_W)) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .up    (up_if),
        .dn    (dn_if)
`ifdef PIPE_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: FIFO of at most two {ctrl,data} words.
    logic [CTRL_W+PW-1:0] mq[$];
    logic [PW-1:0]        m_last;
    logic [31:0]          m_stall;

    typedef struct {
        logic              rst;
        logic              iv;
        logic [CTRL_W-1:0] ic;
        logic [PW-1:0]     id;
        logic              ordy;
        logic              fl;
        logic              eov;
        logic [CTRL_W-1:0] eoc;
        logic [PW-1:0]     eod;
        logic              eir;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic rst, input logic iv, input logic [CTRL_W-1:0] ic,
                                input logic [PW-1:0] id, input logic ordy, input logic fl,
                                input logic eov, input logic [CTRL_W-1:0] eoc,
                                input logic [PW-1:0] eod, input logic eir);
        vec_t v;
        v.rst = rst; v.iv = iv; v.ic = ic; v.id = id; v.ordy = ordy; v.fl = fl;
        v.eov = eov; v.eoc = eoc; v.eod = eod; v.eir = eir;
        return v;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [PW-1:0] act,
                       input logic [PW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s idx=%0d actual=%h required=%h", nm, idx, act, exp);
        end
    endtask

    task automatic model_step(input logic rst, input logic iv, input logic [CTRL_W-1:0] ic,
                              input logic [PW-1:0] id, input logic ordy, input logic fl);
        bit fire, acc;
        if (rst) begin
            mq.delete();
            m_last  = '0;
            m_stall = '0;
            return;
        end
        fire = (mq.size() > 0) && ordy;
        acc  = iv && (mq.size() < 2);
        if (mq.size() > 0 && !ordy) m_stall = m_stall + 1;
        if (fl) begin
            mq.delete();
        end else begin
            if (fire) void'(mq.pop_front());
            if (acc)  mq.push_back({ic, id});
        end
        if (mq.size() > 0) m_last = mq[0][PW-1:0];
    endtask

    task automatic step(input logic rst, input logic iv, input logic [CTRL_W-1:0] ic,
                        input logic [PW-1:0] id, input logic ordy, input logic fl);
        reset        = rst;
        up_if.valid  = iv;
        up_if.ctrl   = ic;
        up_if.data   = id;
        dn_if.ready  = ordy;
        flush        = fl;
        model_step(rst, iv, ic, id, ordy, fl);
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input int idx);
        logic [CTRL_W-1:0] ectrl;
        ectrl = (mq.size() > 0) ? mq[0][CTRL_W+PW-1:PW] : '0;
        chk("rnd_out_valid", idx, PW'(dn_if.valid), PW'(mq.size() > 0));
        chk("rnd_out_ctrl",  idx, PW'(dn_if.ctrl),  PW'(ectrl));
        chk("rnd_out_data",  idx, dn_if.data,       m_last);
        chk("rnd_in_ready",  idx, PW'(up_if.ready), PW'(mq.size() < 2));
`ifdef PIPE_STALL_CNT_EN
        chk("rnd_stall_cnt", idx, PW'(stall_cnt),   PW'(m_stall));
`endif
    endtask

    initial begin
        int n;
        logic [PW-1:0] rdat;

        reset = 1'b1; flush = 1'b0;
        up_if.valid = 1'b0; up_if.ctrl = '0; up_if.data = '0; dn_if.ready = 1'b0;
        m_last = '0; m_stall = '0;

        // Reset with valid input present, then one cycle after release.
        tbl.push_back(mk(1, 1, 1, 64'hAAAA5555_12345678, 0, 0,  0, 0, 64'h0, 1));
        tbl.push_back(mk(1, 1, 1, 64'hAAAA5555_12345678, 0, 0,  0, 0, 64'h0, 1));
        tbl.push_back(mk(0, 0, 1, 64'hAAAA5555_12345678, 0, 0,  0, 0, 64'h0, 1));
        // Streaming words 1..8 at full rate, then drain.
        for (int k = 1; k <= 8; k++)
            tbl.push_back(mk(0, 1, 1, PW'(k), 1, 0,  1, 1, PW'(k), 1));
        tbl.push_back(mk(0, 0, 0, 64'h0, 1, 0,  0, 0, 64'd8, 1));
        // Backpressure: fill to FULL, hold, release one word per cycle.
        tbl.push_back(mk(0, 1, 1, 64'h11, 0, 0,  1, 1, 64'h11, 1));
        tbl.push_back(mk(0, 1, 0, 64'h22, 0, 0,  1, 1, 64'h11, 0));
        tbl.push_back(mk(0, 0, 0, 64'h0,  0, 0,  1, 1, 64'h11, 0));
        tbl.push_back(mk(0, 0, 0, 64'h0,  1, 0,  1, 0, 64'h22, 1));
        tbl.push_back(mk(0, 0, 0, 64'h0,  1, 0,  0, 0, 64'h22, 1));
        // Flush in FULL with input offered; 0x33 must never appear.
        tbl.push_back(mk(0, 1, 1, 64'h44, 0, 0,  1, 1, 64'h44, 1));
        tbl.push_back(mk(0, 1, 1, 64'h55, 0, 0,  1, 1, 64'h44, 0));
        tbl.push_back(mk(0, 1, 1, 64'h33, 0, 1,  0, 0, 64'h44, 1));
        tbl.push_back(mk(0, 0, 0, 64'h0,  0, 0,  0, 0, 64'h44, 1));
        // Flush in ONE beats a simultaneous accept.
        tbl.push_back(mk(0, 1, 1, 64'h66, 0, 0,  1, 1, 64'h66, 1));
        tbl.push_back(mk(0, 1, 1, 64'h77, 0, 1,  0, 0, 64'h66, 1));
        tbl.push_back(mk(0, 0, 0, 64'h0,  0, 0,  0, 0, 64'h66, 1));
        // Flush together with a downstream fire.
        tbl.push_back(mk(0, 1, 1, 64'h88, 0, 0,  1, 1, 64'h88, 1));
        tbl.push_back(mk(0, 0, 0, 64'h0,  1, 1,  0, 0, 64'h88, 1));
        // Bubbles with ctrl asserted upstream stay masked.
        for (int k = 0; k < 3; k++)
            tbl.push_back(mk(0, 0, 1, 64'h0, 0, 0,  0, 0, 64'h88, 1));

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].rst, tbl[i].iv, tbl[i].ic, tbl[i].id, tbl[i].ordy, tbl[i].fl);
            chk("tbl_out_valid", i, PW'(dn_if.valid), PW'(tbl[i].eov));
            chk("tbl_out_ctrl",  i, PW'(dn_if.ctrl),  PW'(tbl[i].eoc));
            chk("tbl_out_data",  i, dn_if.data,       tbl[i].eod);
            chk("tbl_in_ready",  i, PW'(up_if.ready), PW'(tbl[i].eir));
        end

        // Latency from accept in EMPTY to out_valid, bounded wait.
        step(0, 1, 1, 64'hCAFE_0000_0000_BEEF, 0, 0);
        n = 1;
        while (!dn_if.valid && n < 4) begin
            step(0, 0, 0, 64'h0, 0, 0);
            n++;
        end
        chk("accept_latency", 0, PW'(n), PW'(1));
        chk("latency_data",   0, dn_if.data, 64'hCAFE_0000_0000_BEEF);
        step(0, 0, 0, 64'h0, 1, 0);

        // Randomized traffic against the queue model.
        step(1, 0, 0, 64'h0, 0, 0);
        for (int i = 0; i < 400; i++) begin
            rdat = {$urandom(), $urandom()};
            step(($urandom_range(0, 99) < 2),
                 ($urandom_range(0, 99) < 65),
                 CTRL_W'($urandom()),
                 rdat,
                 ($urandom_range(0, 99) < 55),
                 ($urandom_range(0, 99) < 5));
            check_model(i);
        end

`ifdef PIPE_STALL_CNT_EN
        // Five stalled cycles, flush while firing, then reset.
        step(1, 0, 0, 64'h0, 0, 0);
        step(0, 1, 1, 64'h99, 0, 0);
        for (int k = 0; k < 5; k++) step(0, 0, 0, 64'h0, 0, 0);
        chk("stall_after_5", 0, PW'(stall_cnt), PW'(5));
        step(0, 0, 0, 64'h0, 1, 1);
        chk("stall_after_flush", 0, PW'(stall_cnt), PW'(5));
        step(0, 0, 0, 64'h0, 0, 0);
        chk("stall_idle", 0, PW'(stall_cnt), PW'(5));
        step(1, 0, 0, 64'h0, 0, 0);
        chk("stall_after_reset", 0, PW'(stall_cnt), PW'(0));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
